uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Receive side of the 8N1 UART link. Recovers bytes from the serial line using a run-time
//  bit period (clock cycles per bit) and samples each bit at its midpoint. Reports each
//  received byte with a one-cycle done strobe and flags stop-bit framing errors.
//  Sits beside the UART transmitter in the UART peripheral; both share the same CLKS_PER_BIT register.
// PARAMETERS
//  SYNC_STAGES  2  depth of the i_RX_Serial metastability synchronizer (minimum 2)
// PORTS
//  clk_i           in   1   system clock; single clock domain
//  rst_i           in   1   synchronous, active-high reset
//  rx_en           in   1   1 = start-bit detection armed; 0 = no new frame is accepted
//  i_RX_Serial     in   1   asynchronous serial line; idles high
//  CLKS_PER_BIT    in   16  clk_i cycles per bit; captured at start-bit detect
//  o_RX_Byte       out  8   last good byte; LSB is the first bit received
//  o_RX_Done       out  1   one-cycle pulse when o_RX_Byte is updated
//  o_RX_Frame_Err  out  1   one-cycle pulse: stop bit sampled low
//  o_RX_Busy       out  1   high from start-bit detect until return to IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; synchronizer flops preset to 1; counters 0.
//  rx_s = i_RX_Serial after SYNC_STAGES flops. This adds SYNC_STAGES cycles of latency.
//  Bit period P = max(CLKS_PER_BIT, 2), latched into r_Period on the IDLE->START transition.
//  P cannot change mid-frame. r_Clock_Count is 16 bits and never wraps; compares use r_Period-1.
//  States (3-bit): IDLE, START, DATA, STOP, CLEANUP, BREAK (plus PARITY when the macro is set).
//   IDLE:    counters cleared. rx_en=1 and rx_s=0 -> START, o_RX_Busy<=1.
//            rx_en=0 -> stay in IDLE; a frame already in progress is always completed.
//   START:   count to (P>>1)-1, then resample rx_s.
//            rx_s=1 -> glitch: go to IDLE with no pulse. Otherwise clear the count -> DATA.
//   DATA:    count to P-1, then shift rx_s into r_Byte[r_Bit_Index] and clear the count.
//            After index 7 -> STOP (or PARITY). Sampling therefore stays at mid-bit.
//   STOP:    count to P-1, then sample.
//            rx_s=1 -> o_RX_Byte<=r_Byte, o_RX_Done<=1, go to CLEANUP.
//            rx_s=0 -> o_RX_Frame_Err<=1, o_RX_Byte is left unchanged, go to BREAK.
//   CLEANUP: one cycle; pulses drop; o_RX_Busy<=0 -> IDLE.
//   BREAK:   hold until rx_s=1 (line-break or stuck-low guard), then o_RX_Busy<=0 -> IDLE.
//            This prevents a held-low line from re-triggering frames.
//  Pulses are exactly one cycle. o_RX_Done and o_RX_Frame_Err are never high together.
//  Back-to-back frames: a start edge seen in the cycle after CLEANUP is accepted.
//  Reset mid-frame: the frame is abandoned with no pulse and o_RX_Byte clears to 0.
//  unknown state -> IDLE.
// CONFIGURATION
//  `UART_RX_PARITY_EN defined: adds ports parity_odd (in, 1) and o_RX_Parity_Err (out, 1).
//   PARITY state follows DATA: count P-1, then sample. Expected bit = ^r_Byte ^ parity_odd.
//   On mismatch, o_RX_Parity_Err pulses together with the STOP outcome.
//   The byte is still delivered if the stop bit is good.
//  Undefined: no parity ports and no PARITY state; strict 8N1.
// STRUCTURE
//  Package uart_pkg: state localparams (IDLE..BREAK, PARITY), UART_DATA_BITS=8, UART_MIN_CPB=2.
//  Shared with the transmitter.
//  Sub-module uart_sync: SYNC_STAGES-deep flop chain with set-to-1 reset, instanced for i_RX_Serial.
//  FSM, counters and shift register live in uart_rx itself.
// TESTING
//  1. CLKS_PER_BIT=16, send 0xA5 8N1 -> o_RX_Byte=0xA5.
//     o_RX_Done pulses once, 1 cycle, about 152+SYNC_STAGES cycles after the start edge.
//     o_RX_Busy then falls.
//  2. CLKS_PER_BIT=16, 3-cycle low glitch on idle line -> no pulse; o_RX_Busy falls within 8 cycles.
//  3. CLKS_PER_BIT=10, 0x3C with stop bit forced low, then line held low for 50 cycles.
//     Expect o_RX_Frame_Err pulse and o_RX_Byte unchanged.
//     No new frame until the line goes high; the next 0x81 is received correctly.
//  4. CLKS_PER_BIT=8, frames 0x00, 0xFF, 0x55 with zero idle between them -> three done pulses.
//  5. Change CLKS_PER_BIT from 16 to 32 mid-frame, and separately assert rst_i at bit 4.
//     The frame in flight still decodes at 16. Reset yields no pulse and o_RX_Byte=0.
//  6. `UART_RX_PARITY_EN, parity_odd=0, 0x07 with parity bit 0 -> o_RX_Parity_Err pulse.
//     With parity bit 1 -> clean o_RX_Done, o_RX_Byte=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and link constants.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_MIN_CPB   = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4,
    BREAK   = 3'd5,
    PARITY  = 3'd6
  } uart_state_e;

  function automatic logic [15:0] clamp_cpb(
    input logic [15:0] cpb
  );
    return (cpb < 16'(UART_MIN_CPB)) ?
           16'(UART_MIN_CPB) : cpb;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Metastability synchronizer for an asynchronous input.
// Flops reset to 1 so an idle-high line never looks like a start edge.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '1;
    else       sync_q <= sync_d;
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and stop-bit framing check.
// Optional parity stage when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_en,
  input  logic        i_RX_Serial,
  input  logic [15:0] CLKS_PER_BIT,
`ifdef UART_RX_PARITY_EN
  input  logic        parity_odd,
  output logic        o_RX_Parity_Err,
`endif
  output logic [7:0]  o_RX_Byte,
  output logic        o_RX_Done,
  output logic        o_RX_Frame_Err,
  output logic        o_RX_Busy
);

  logic rx_s;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (i_RX_Serial),
    .q_o   (rx_s)
  );

  uart_state_e state_q, state_d;
  logic [15:0] period_q, period_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic        pbad_q, pbad_d;
  logic        perr_q, perr_d;
`endif

  logic [15:0] half_m1;
  logic [15:0] full_m1;

  assign half_m1 = (period_q >> 1) - 16'd1;
  assign full_m1 = period_q - 16'd1;

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    rx_byte_d = rx_byte_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    busy_d    = busy_q;
`ifdef UART_RX_PARITY_EN
    pbad_d    = pbad_q;
    perr_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
`ifdef UART_RX_PARITY_EN
        pbad_d = 1'b0;
`endif
        if (rx_en && !rx_s) begin
          state_d  = START;
          busy_d   = 1'b1;
          period_d = clamp_cpb(CLKS_PER_BIT);
        end
      end
      START: begin
        if (cnt_q == half_m1) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == full_m1) begin
          cnt_d         = '0;
          byte_d[idx_q] = rx_s;
          idx_d         = idx_q + 3'd1;
          if (idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == full_m1) begin
          cnt_d   = '0;
          pbad_d  = rx_s ^ (^byte_q) ^ parity_odd;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == full_m1) begin
          cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          perr_d = pbad_q;
`endif
          if (rx_s) begin
            rx_byte_d = byte_q;
            done_d    = 1'b1;
            state_d   = CLEANUP;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      CLEANUP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      BREAK: begin
        // Wait for the line to release so a stuck-low line cannot re-trigger.
        if (rx_s) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      period_q  <= 16'(UART_MIN_CPB);
      cnt_q     <= '0;
      idx_q     <= '0;
      byte_q    <= '0;
      rx_byte_q <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q    <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      byte_q    <= byte_d;
      rx_byte_q <= rx_byte_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
      pbad_q    <= pbad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign o_RX_Byte      = rx_byte_q;
  assign o_RX_Done      = done_q;
  assign o_RX_Frame_Err = ferr_q;
  assign o_RX_Busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign o_RX_Parity_Err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed scoreboard bench for uart_rx.
// Parity cases are built only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        rx_en;
  logic        rx;
  logic [15:0] cpb;
  logic [7:0]  o_RX_Byte;
  logic        o_RX_Done;
  logic        o_RX_Frame_Err;
  logic        o_RX_Busy;
`ifdef UART_RX_PARITY_EN
  logic        parity_odd;
  logic        o_RX_Parity_Err;
`endif

  always #5 clk = ~clk;

  uart_rx #(
    .SYNC_STAGES (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .rx_en          (rx_en),
    .i_RX_Serial    (rx),
    .CLKS_PER_BIT   (cpb),
`ifdef UART_RX_PARITY_EN
    .parity_odd     (parity_odd),
    .o_RX_Parity_Err(o_RX_Parity_Err),
`endif
    .o_RX_Byte      (o_RX_Byte),
    .o_RX_Done      (o_RX_Done),
    .o_RX_Frame_Err (o_RX_Frame_Err),
    .o_RX_Busy      (o_RX_Busy)
  );

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_good = 8'h00;
  logic       prev_pulse = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic hold(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input int p,
                      input logic stop_b,
                      input logic use_par,
                      input logic par_b);
    hold(1'b0, p);
    for (int i = 0; i < 8; i++) hold(d[i], p);
    if (use_par) hold(par_b, p);
    hold(stop_b, p);
  endtask

  task automatic expect_frame(input logic [7:0] d,
                              input logic ferr,
                              input logic perr);
    exp_t e;
    e.ferr = ferr;
    e.data = ferr ? last_good : d;
    e.perr = perr;
    sb.push_back(e);
    if (!ferr) last_good = d;
  endtask

  task automatic wait_idle(input string tag,
                           input int budget);
    int n = 0;
    while ((sb.size() != 0 || o_RX_Busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  always @(negedge clk) begin
    if (o_RX_Done || o_RX_Frame_Err) begin
      chk("done_ferr_excl", 32'(o_RX_Done & o_RX_Frame_Err), 0);
      chk("pulse_width", 32'(prev_pulse), 0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("frame_err_flag", 32'(o_RX_Frame_Err), 32'(e.ferr));
        chk("rx_byte", 32'(o_RX_Byte), 32'(e.data));
`ifdef UART_RX_PARITY_EN
        chk("parity_err", 32'(o_RX_Parity_Err), 32'(e.perr));
`endif
      end
    end
`ifdef UART_RX_PARITY_EN
    else if (o_RX_Parity_Err) begin
      chk("parity_alone", 32'd1, 32'd0);
    end
`endif
    prev_pulse = o_RX_Done | o_RX_Frame_Err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int n_hi;
    rst_i = 1'b1;
    rx_en = 1'b1;
    rx    = 1'b1;
    cpb   = 16'd16;
`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
`endif
    repeat (4) @(negedge clk);
    chk("rst_byte", 32'(o_RX_Byte), 0);
    chk("rst_done", 32'(o_RX_Done), 0);
    chk("rst_ferr", 32'(o_RX_Frame_Err), 0);
    chk("rst_busy", 32'(o_RX_Busy), 0);
    rst_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", 32'(o_RX_Busy), 0);

    // 1: basic frame and latency
    expect_frame(8'hA5, 1'b0, 1'b0);
    n = 0;
    fork
      send(8'hA5, 16, 1'b1, 1'b0, 1'b0);
      begin
        while (!o_RX_Done && n < 400) begin
          @(negedge clk);
          n++;
        end
        chk("t1_busy_at_done", 32'(o_RX_Busy), 1);
      end
    join
    chk("t1_latency", 32'(n >= 150 && n <= 160), 1);
    hold(1'b1, 4);
    chk("t1_busy_fell", 32'(o_RX_Busy), 0);
    chk("t1_sb_empty", 32'(sb.size()), 0);

    // 2: short glitch is rejected
    hold(1'b0, 3);
    n_hi = 0;
    for (int i = 0; i < 24; i++) begin
      rx = 1'b1;
      @(negedge clk);
      if (o_RX_Busy) n_hi++;
    end
    chk("t2_busy_rose", 32'(n_hi > 0), 1);
    chk("t2_busy_len", 32'(n_hi <= 8), 1);
    chk("t2_byte_kept", 32'(o_RX_Byte), 32'hA5);

    // rx_en low: no frame is accepted
    rx_en = 1'b0;
    send(8'h12, 16, 1'b1, 1'b0, 1'b0);
    chk("en_busy", 32'(o_RX_Busy), 0);
    rx_en = 1'b1;
    hold(1'b1, 10);

    // 3: framing error and held-low line
    cpb = 16'd10;
    expect_frame(8'h3C, 1'b1, 1'b0);
    send(8'h3C, 10, 1'b0, 1'b0, 1'b0);
    hold(1'b0, 50);
    chk("t3_break_busy", 32'(o_RX_Busy), 1);
    chk("t3_byte_kept", 32'(o_RX_Byte), 32'hA5);
    chk("t3_sb_empty", 32'(sb.size()), 0);
    hold(1'b1, 30);
    chk("t3_released", 32'(o_RX_Busy), 0);
    expect_frame(8'h81, 1'b0, 1'b0);
    send(8'h81, 10, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 20);
    wait_idle("t3_idle", 200);

    // 4: back-to-back frames
    cpb = 16'd8;
    expect_frame(8'h00, 1'b0, 1'b0);
    expect_frame(8'hFF, 1'b0, 1'b0);
    expect_frame(8'h55, 1'b0, 1'b0);
    send(8'h00, 8, 1'b1, 1'b0, 1'b0);
    send(8'hFF, 8, 1'b1, 1'b0, 1'b0);
    send(8'h55, 8, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 20);
    wait_idle("t4_idle", 200);

    // 5a: period change mid-frame is ignored
    cpb = 16'd16;
    hold(1'b1, 20);
    expect_frame(8'h3A, 1'b0, 1'b0);
    fork
      send(8'h3A, 16, 1'b1, 1'b0, 1'b0);
      begin
        repeat (40) @(negedge clk);
        cpb = 16'd32;
      end
    join
    hold(1'b1, 20);
    wait_idle("t5_idle", 200);
    cpb = 16'd16;

    // 5b: reset during bit 4
    hold(1'b1, 20);
    fork
      send(8'hF5, 16, 1'b1, 1'b0, 1'b0);
      begin
        repeat (88) @(negedge clk);
        chk("t5_pre_rst_byte", 32'(o_RX_Byte), 32'h3A);
        chk("t5_pre_rst_busy", 32'(o_RX_Busy), 1);
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
      end
    join
    last_good = 8'h00;
    hold(1'b1, 20);
    chk("t5_rst_byte", 32'(o_RX_Byte), 0);
    chk("t5_rst_busy", 32'(o_RX_Busy), 0);

`ifdef UART_RX_PARITY_EN
    // 6: parity check, even parity selected
    parity_odd = 1'b0;
    expect_frame(8'h07, 1'b0, 1'b1);
    send(8'h07, 16, 1'b1, 1'b1, 1'b0);
    hold(1'b1, 20);
    wait_idle("t6_bad_idle", 200);
    expect_frame(8'h07, 1'b0, 1'b0);
    send(8'h07, 16, 1'b1, 1'b1, 1'b1);
    hold(1'b1, 20);
    wait_idle("t6_good_idle", 200);
    chk("t6_byte", 32'(o_RX_Byte), 32'h07);
`endif

    chk("final_sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
